// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter that shares one Wishbone slave port among NUM_PORTS masters.
// A grant holds until ack, abort, or watchdog expiry; the watchdog force-completes hung transfers.
module wishbone_rr_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int WB_ADR_WIDTH   = 37,
  parameter int WB_DAT_SIZE    = 3,
  parameter int WB_DAT_WIDTH   = 32'd8 << WB_DAT_SIZE,
  parameter int WB_SEL_WIDTH   = 32'd1 << WB_DAT_SIZE,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [WB_DAT_WIDTH-1:0] TIMEOUT_DATA = {WB_DAT_WIDTH{1'b1}}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS*WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [NUM_PORTS*WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [NUM_PORTS*WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [NUM_PORTS*WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic [NUM_PORTS-1:0]              s_wb_we_i,
  input  logic [NUM_PORTS-1:0]              s_wb_stb_i,
  output logic [NUM_PORTS-1:0]              s_wb_ack_o,
  output logic [WB_ADR_WIDTH-1:0]           m_wb_adr_o,
  input  logic [WB_DAT_WIDTH-1:0]           m_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]           m_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]           m_wb_sel_o,
  output logic                              m_wb_we_o,
  output logic                              m_wb_stb_o,
  input  logic                              m_wb_ack_i,
  output logic [NUM_PORTS-1:0]              grant,
  output logic                              busy,
  output logic                              timeout_flag,
  output logic [2:0]                        timeout_port,
  input  logic                              timeout_clear
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic WDOG_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 state_r;
  logic [NUM_PORTS-1:0]   grant_r;
  logic [2:0]             gidx_r;
  logic [2:0]             rr_ptr_r;
  logic [CNT_W-1:0]       wdog_cnt_r;
  logic                   timeout_flag_r;
  logic [2:0]             timeout_port_r;

  logic                   pick_found_s;
  logic [2:0]             pick_idx_s;
  logic [NUM_PORTS-1:0]   pick_onehot_s;
  logic                   busy_s;
  logic                   stb_g_s;
  logic                   expire_s;
  logic                   done_s;
  logic [2:0]             rr_next_s;
  logic [WB_DAT_WIDTH-1:0] rdata_s;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int  cand;
    logic hit;
    pick_found_s = 1'b0;
    pick_idx_s   = 3'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = ((int'(rr_ptr_r) + i) >= NUM_PORTS) ? (int'(rr_ptr_r) + i - NUM_PORTS)
                                                  : (int'(rr_ptr_r) + i);
      for (int p = 0; p < NUM_PORTS; p++) begin
        hit          = !pick_found_s && (cand == p) && s_wb_stb_i[p];
        pick_found_s = pick_found_s | hit;
        pick_idx_s   = hit ? 3'(p) : pick_idx_s;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      pick_onehot_s[p] = (pick_idx_s == 3'(p));
    end
  end

  // Route the granted master's request to the bridge; grant_r is zero when idle.
  always_comb begin
    m_wb_adr_o = {WB_ADR_WIDTH{1'b0}};
    m_wb_dat_o = {WB_DAT_WIDTH{1'b0}};
    m_wb_sel_o = {WB_SEL_WIDTH{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      m_wb_adr_o = m_wb_adr_o | (grant_r[p] ? s_wb_adr_i[p*WB_ADR_WIDTH +: WB_ADR_WIDTH]
                                            : {WB_ADR_WIDTH{1'b0}});
      m_wb_dat_o = m_wb_dat_o | (grant_r[p] ? s_wb_dat_i[p*WB_DAT_WIDTH +: WB_DAT_WIDTH]
                                            : {WB_DAT_WIDTH{1'b0}});
      m_wb_sel_o = m_wb_sel_o | (grant_r[p] ? s_wb_sel_i[p*WB_SEL_WIDTH +: WB_SEL_WIDTH]
                                            : {WB_SEL_WIDTH{1'b0}});
    end
  end

  // An ack racing the expiry wins; a withdrawn strobe is an abort, not a timeout.
  always_comb begin
    busy_s     = (state_r == ST_BUSY);
    stb_g_s    = |(grant_r & s_wb_stb_i);
    expire_s   = WDOG_EN && busy_s && stb_g_s && !m_wb_ack_i && (wdog_cnt_r == CNT_LAST);
    done_s     = busy_s && (m_wb_ack_i || !stb_g_s || expire_s);
    rr_next_s  = (gidx_r == 3'(NUM_PORTS - 1)) ? 3'd0 : (gidx_r + 3'd1);
    rdata_s    = expire_s ? TIMEOUT_DATA : m_wb_dat_i;
    m_wb_we_o  = |(grant_r & s_wb_we_i);
    m_wb_stb_o = stb_g_s && busy_s && !expire_s;
    s_wb_ack_o = grant_r & {NUM_PORTS{m_wb_ack_i | expire_s}};
    s_wb_dat_o = {NUM_PORTS{rdata_s}};
  end

  // Arbitration state, round-robin pointer, watchdog and sticky timeout status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      grant_r        <= {NUM_PORTS{1'b0}};
      gidx_r         <= 3'd0;
      rr_ptr_r       <= 3'd0;
      wdog_cnt_r     <= {CNT_W{1'b0}};
      timeout_flag_r <= 1'b0;
      timeout_port_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r    <= ST_BUSY;
            grant_r    <= pick_onehot_s;
            gidx_r     <= pick_idx_s;
            wdog_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (done_s) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_PORTS{1'b0}};
            rr_ptr_r   <= rr_next_s;
          end else begin
            wdog_cnt_r <= wdog_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {NUM_PORTS{1'b0}};
        end
      endcase
      if (expire_s) begin
        timeout_flag_r <= 1'b1;
        timeout_port_r <= gidx_r;
      end else if (timeout_clear) begin
        timeout_flag_r <= 1'b0;
      end else begin
        timeout_flag_r <= timeout_flag_r;
      end
    end
  end

  assign grant        = grant_r;
  assign busy         = busy_s;
  assign timeout_flag = timeout_flag_r;
  assign timeout_port = timeout_port_r;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Randomized bench for wishbone_rr_arbiter: masters, bridge responder and a
// transaction-level reference model that predicts every output each cycle.
module tb_wishbone_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 37;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*AW-1:0] s_wb_adr_i;
  logic [N*DW-1:0] s_wb_dat_i;
  logic [N*DW-1:0] s_wb_dat_o;
  logic [N*SW-1:0] s_wb_sel_i;
  logic [N-1:0]    s_wb_we_i;
  logic [N-1:0]    s_wb_stb_i;
  logic [N-1:0]    s_wb_ack_o;
  logic [AW-1:0]   m_wb_adr_o;
  logic [DW-1:0]   m_wb_dat_i;
  logic [DW-1:0]   m_wb_dat_o;
  logic [SW-1:0]   m_wb_sel_o;
  logic            m_wb_we_o;
  logic            m_wb_stb_o;
  logic            m_wb_ack_i;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_flag;
  logic [2:0]      timeout_port;
  logic            timeout_clear;

  wishbone_rr_arbiter #(
    .NUM_PORTS(N), .WB_ADR_WIDTH(AW), .WB_DAT_SIZE(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_we_i(s_wb_we_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o), .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i), .grant(grant), .busy(busy),
    .timeout_flag(timeout_flag), .timeout_port(timeout_port), .timeout_clear(timeout_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner is the granted port (-1 when idle), cnt the BUSY cycle index.
  int owner, rr, cnt, lat, tport;
  bit flag;
  bit req[N];
  bit acked[N];
  bit mask[N];
  logic [AW-1:0] adr[N];
  logic [DW-1:0] wdat[N];
  logic [SW-1:0] sel[N];
  bit we[N];
  bit all_req;
  int fixed_lat;
  int clear_mode;
  logic [N-1:0] obs_q[$];
  logic [N-1:0] prev_grant;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; rr = 0; cnt = 0; lat = 1; tport = 0; flag = 1'b0;
    for (int p = 0; p < N; p++) begin
      req[p] = 1'b0; acked[p] = 1'b0;
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < N; p++) begin
      s_wb_adr_i[p*AW +: AW] = adr[p];
      s_wb_dat_i[p*DW +: DW] = wdat[p];
      s_wb_sel_i[p*SW +: SW] = sel[p];
      s_wb_we_i[p]           = we[p];
      s_wb_stb_i[p]          = req[p];
    end
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+3, advance the model.
  task automatic step();
    logic [N-1:0] e_grant, e_ack;
    bit stbg, expire, found;
    int pick, c, r;
    for (int p = 0; p < N; p++) begin
      if (acked[p]) req[p] = 1'b0;
      if (!req[p] && mask[p] && (all_req || $urandom_range(3) == 0)) begin
        req[p]  = 1'b1;
        adr[p]  = AW'({$urandom, $urandom});
        wdat[p] = {$urandom, $urandom};
        sel[p]  = SW'($urandom);
        we[p]   = $urandom_range(1) == 1;
      end else if (req[p] && !all_req && p == owner && $urandom_range(79) == 0) begin
        req[p] = 1'b0;
      end
    end
    drive_ports();
    if (owner >= 0) m_wb_ack_i = req[owner] && (cnt + 1 >= lat);
    else            m_wb_ack_i = ($urandom_range(15) == 0);
    m_wb_dat_i = {$urandom, $urandom};
    timeout_clear = (clear_mode == 0) ? ($urandom_range(7) == 0) : (clear_mode == 2);
    #2;
    stbg    = (owner >= 0) && req[owner];
    expire  = stbg && (cnt == TO - 1) && !m_wb_ack_i;
    e_grant = (owner >= 0) ? N'(1 << owner) : '0;
    e_ack   = ((owner >= 0) && (m_wb_ack_i || expire)) ? N'(1 << owner) : '0;
    check_eq("grant", grant, e_grant);
    check_eq("busy", busy, owner >= 0);
    check_eq("m_stb", m_wb_stb_o, stbg && !expire);
    check_eq("s_ack", s_wb_ack_o, e_ack);
    check_eq("tflag", timeout_flag, flag);
    check_eq("tport", timeout_port, tport);
    for (int p = 0; p < N; p++)
      check_eq("s_dat", s_wb_dat_o[p*DW +: DW], expire ? {DW{1'b1}} : m_wb_dat_i);
    if (owner >= 0) begin
      check_eq("m_adr", m_wb_adr_o, adr[owner]);
      check_eq("m_dat", m_wb_dat_o, wdat[owner]);
      check_eq("m_sel", m_wb_sel_o, sel[owner]);
      check_eq("m_we", m_wb_we_o, we[owner]);
    end
    if (grant !== prev_grant && grant !== '0) obs_q.push_back(grant);
    prev_grant = grant;
    for (int p = 0; p < N; p++) acked[p] = e_ack[p];
    if (expire) begin
      flag = 1'b1; tport = owner;
    end else if (timeout_clear) begin
      flag = 1'b0;
    end
    if (owner < 0) begin
      found = 1'b0; pick = 0;
      for (int i = 0; i < N; i++) begin
        c = (rr + i) % N;
        if (!found && req[c]) begin found = 1'b1; pick = c; end
      end
      if (found) begin
        owner = pick; cnt = 0;
        r = $urandom_range(9);
        if (fixed_lat != 0) lat = fixed_lat;
        else if (r == 0)    lat = 100;
        else if (r == 1)    lat = TO;
        else                lat = $urandom_range(4, 1);
      end
    end else if (m_wb_ack_i || !stbg || expire) begin
      rr = (owner + 1) % N; owner = -1;
    end else begin
      cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_masks(input bit v);
    for (int p = 0; p < N; p++) mask[p] = v;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0; s_wb_we_i = '0; s_wb_stb_i = '0;
    m_wb_ack_i = 1'b0; m_wb_dat_i = '0; timeout_clear = 1'b0;
    for (int p = 0; p < N; p++) begin
      adr[p] = '0; wdat[p] = '0; sel[p] = '0; we[p] = 1'b0; mask[p] = 1'b0;
    end
    all_req = 1'b0; fixed_lat = 0; clear_mode = 1; prev_grant = '0;
    model_reset();
    #12;
    check_eq("rst_grant", grant, 4'b0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_mstb", m_wb_stb_o, 1'b0);
    check_eq("rst_ack", s_wb_ack_o, 4'b0000);
    check_eq("rst_tflag", timeout_flag, 1'b0);
    check_eq("rst_tport", timeout_port, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single write from port 1, bridge acks on the third BUSY cycle.
    req[1] = 1'b1; adr[1] = 37'h0_0000_0010; wdat[1] = 64'h1122334455667788;
    sel[1] = 8'hFF; we[1] = 1'b1; fixed_lat = 3;
    run(8);

    // All ports requesting continuously from reset: grants rotate 0,1,2,3,0,1.
    pulse_reset();
    set_masks(1'b1); all_req = 1'b1; fixed_lat = 2;
    obs_q.delete();
    run(24);
    all_req = 1'b0; set_masks(1'b0);
    check_eq("rot_count", obs_q.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check_eq("rot_order", obs_q[i], 4'b0001 << (i % 4));
    run(30);

    // Bridge never acks port 0: watchdog completes it with all-ones data.
    clear_mode = 2; run(1); clear_mode = 1;
    req[0] = 1'b1; we[0] = 1'b0; fixed_lat = 100;
    run(20);
    check_eq("to_flag", timeout_flag, 1'b1);
    check_eq("to_port", timeout_port, 3'd0);

    // Ack coincides with expiry: normal completion, flag stays clear.
    clear_mode = 2; run(1); clear_mode = 1;
    req[3] = 1'b1; fixed_lat = TO;
    run(20);
    check_eq("coinc_flag", timeout_flag, 1'b0);

    // Randomized traffic from all masters.
    set_masks(1'b1); fixed_lat = 0; clear_mode = 0;
    run(3000);
    set_masks(1'b0); clear_mode = 1;
    run(60);

    // Asynchronous reset in the middle of a port 2 transaction.
    req[2] = 1'b1; fixed_lat = 100;
    run(3);
    check_eq("pre_rst_grant", grant, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_grant", grant, 4'b0000);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_mstb", m_wb_stb_o, 1'b0);
    check_eq("arst_ack", s_wb_ack_o, 4'b0000);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req[0] = 1'b1; req[2] = 1'b1; fixed_lat = 2;
    obs_q.delete(); prev_grant = '0;
    run(10);
    check_eq("post_rst_cnt", obs_q.size() >= 1, 1'b1);
    if (obs_q.size() >= 1) check_eq("post_rst_first", obs_q[0], 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
Shares one Wishbone slave port, the single-beat Wishbone-to-AXI4-Lite peripheral bridge, between NUM_PORTS Wishbone masters. Masters are typically the testbench host, a DMA sequencer and core-side config logic. Arbitration is round-robin, and a grant holds until the transaction completes. A cycle-count watchdog terminates hung transactions so a stalled AXI4-Lite slave cannot lock up the core clock domain.

Parameters:
NUM_PORTS, 4, number of requesting masters (2..8)
WB_ADR_WIDTH, 37, word address width
WB_DAT_SIZE, 3, data width = 8<<WB_DAT_SIZE bits (3 → 64b); sel width = 1<<WB_DAT_SIZE
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; 0 disables the watchdog
TIMEOUT_DATA, all ones, read data returned on timeout (width WB_DAT_WIDTH)

Ports:
reset  in  1  asynchronous, active-high
clk  in  1  single clock; arbiter and bridge share it
s_wb_adr_i  in  NUM_PORTS*WB_ADR_WIDTH  packed per-port address; port p at slice p
s_wb_dat_i  in  NUM_PORTS*WB_DAT_WIDTH  packed write data
s_wb_dat_o  out  NUM_PORTS*WB_DAT_WIDTH  packed read data
s_wb_sel_i  in  NUM_PORTS*WB_SEL_WIDTH  packed byte selects
s_wb_we_i  in  NUM_PORTS  write enable per port
s_wb_stb_i  in  NUM_PORTS  request per port
s_wb_ack_o  out  NUM_PORTS  acknowledge per port
m_wb_adr_o  out  WB_ADR_WIDTH  to bridge
m_wb_dat_i  in  WB_DAT_WIDTH  from bridge
m_wb_dat_o  out  WB_DAT_WIDTH  to bridge
m_wb_sel_o  out  WB_SEL_WIDTH  to bridge
m_wb_we_o  out  1  to bridge
m_wb_stb_o  out  1  to bridge
m_wb_ack_i  in  1  from bridge
grant  out  NUM_PORTS  one-hot current owner; 0 when idle
busy  out  1  high in BUSY state
timeout_flag  out  1  sticky; set on watchdog expiry
timeout_port  out  3  index of the port that timed out (last event)
timeout_clear  in  1  clears timeout_flag

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, rr pointer=0, watchdog counter=0, timeout_flag=0, timeout_port=0. All s_wb_ack_o=0, m_wb_stb_o=0.
- State IDLE:
  - If any s_wb_stb_i is high, pick the first requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
  - Register its one-hot grant and go to BUSY at the next edge.
  - No requests: remain in IDLE.
- State BUSY, combinational routing:
  - m_wb_adr_o, m_wb_dat_o, m_wb_sel_o and m_wb_we_o come from the granted slice.
  - m_wb_stb_o = s_wb_stb_i[granted] AND state==BUSY.
  - s_wb_ack_o[granted] = m_wb_ack_i; all other acks are 0.
  - Every slice of s_wb_dat_o = m_wb_dat_i. Only the acked port may sample it.
- Completion: on m_wb_ack_i in BUSY, go to IDLE at the next edge, rr pointer = granted+1 (wrap), grant=0.
  - Minimum handoff is one IDLE bubble cycle. Back-to-back transactions from one master therefore take at least 2 cycles plus the bridge latency.
- Request latency: stb rises in cycle n with arbiter IDLE → m_wb_stb_o high in cycle n+1.
- Master withdraws stb while BUSY without ack (protocol abort): m_wb_stb_o drops the same cycle. Go to IDLE next edge; the rr pointer still advances. An m_wb_ack_i arriving in IDLE is dropped and routed to nobody.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When counter == TIMEOUT_CYCLES-1 with no ack:
    - Force s_wb_ack_o[granted]=1 for that one cycle, with s_wb_dat_o = TIMEOUT_DATA.
    - Force m_wb_stb_o=0 that cycle.
    - Set timeout_flag and latch timeout_port.
    - Go to IDLE; the rr pointer advances as on normal completion.
  - If a real ack coincides with expiry, treat it as normal completion and do not set the flag.
- timeout_flag: timeout_clear deasserts it next edge. A simultaneous new timeout wins and the flag stays set.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,3,0…; no port waits more than NUM_PORTS-1 transactions.
- Counter width: clog2(TIMEOUT_CYCLES+1). Grant index width: 3 bits (NUM_PORTS ≤ 8).

Test Plan:
- Single port 1 write, adr=0x0_0000_0010, dat=0x1122334455667788, sel=0xFF, bridge acks 3 cycles after stb → m_wb_stb_o rises 1 cycle after request; ack only on s_wb_ack_o[1]; grant=0b0010 during BUSY.
- All 4 ports request continuously from reset, bridge acks after 2 cycles → grant order 0,1,2,3,0,1; no port skipped or repeated.
- Ports 2 and 3 request while rr pointer=3 → port 3 served first, then port 2; port 2 waits exactly one transaction.
- TIMEOUT_CYCLES=16, bridge never acks port 0 read → s_wb_ack_o[0] pulses in BUSY cycle 16, dat=all ones; timeout_flag=1; timeout_port=0; next requester granted afterwards.
- Ack and timeout coincide at cycle 16 with rdata=0xA5 → port receives 0xA5; timeout_flag stays 0.
- Reset asserted mid-BUSY (port 2 granted) → grant, busy, m_wb_stb_o and all acks go 0 immediately without waiting for clk; after release, port 0 is granted first.
